// File: rtl/countdown_timer_pkg.sv
// Shared types and default widths for the countdown timer.
// Imported by countdown_timer and tick_prescaler.
package countdown_timer_pkg;

    localparam int COUNTER_BITS_DEF  = 32;
    localparam int PRESCALE_BITS_DEF = 16;
    localparam int STATE_W           = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_HOLD,
        ST_EXPIRED
    } state_e;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// tick_prescaler: raises o_tick once every i_div+1 enabled clocks.
// Ports: i_clk, i_rst_n (sync, active-low), i_en, i_clr, i_div, o_tick.
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int PRESCALE_BITS = PRESCALE_BITS_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic [PRESCALE_BITS-1:0] i_div,
    output logic                     o_tick
);

    logic [PRESCALE_BITS-1:0] cnt_q, cnt_d;

    // Clear beats enable; a held enable-low freezes the phase.
    always_comb begin
        cnt_d  = cnt_q;
        o_tick = 1'b0;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            if (cnt_q == i_div) begin
                cnt_d  = '0;
                o_tick = 1'b1;
            end else begin
                cnt_d = cnt_q + PRESCALE_BITS'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, sticky underflow and done pulse.
// Ports: i_CLK, i_RST_N (sync, active-low), i_LOAD, i_VALUE, i_START,
//   i_PAUSE, i_PRESCALE in; o_COUNT, o_BUSY, o_UNDERFLOW, o_DONE out.
// Build option: COUNTDOWN_AUTO_RELOAD_EN reloads and keeps running on expiry.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int COUNTER_BITS  = COUNTER_BITS_DEF,
    parameter int PRESCALE_BITS = PRESCALE_BITS_DEF
) (
    input  logic                     i_CLK,
    input  logic                     i_RST_N,
    input  logic                     i_LOAD,
    input  logic [COUNTER_BITS-1:0]  i_VALUE,
    input  logic                     i_START,
    input  logic                     i_PAUSE,
    input  logic [PRESCALE_BITS-1:0] i_PRESCALE,
    output logic [COUNTER_BITS-1:0]  o_COUNT,
    output logic                     o_BUSY,
    output logic                     o_UNDERFLOW,
    output logic                     o_DONE
);

    state_e                   state_q, state_d;
    logic [COUNTER_BITS-1:0]  count_q, count_d;
    logic [COUNTER_BITS-1:0]  reload_q, reload_d;
    logic [PRESCALE_BITS-1:0] presc_q, presc_d;
    logic                     uf_q, uf_d;
    logic                     done_q, done_d;

    logic busy, pre_en, pre_clr, tick;
    logic start_ok, expire;

    assign start_ok = i_START &&
                      (state_q == ST_ARMED || state_q == ST_EXPIRED);

    // A count of 0 expires on its first tick just like a count of 1.
    assign expire = tick && (count_q <= COUNTER_BITS'(1));

    tick_prescaler #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_presc (
        .i_clk   (i_CLK),
        .i_rst_n (i_RST_N),
        .i_en    (pre_en),
        .i_clr   (pre_clr),
        .i_div   (presc_q),
        .o_tick  (tick)
    );

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_LOAD) begin
            state_d = i_START ? ST_RUN : ST_ARMED;
        end else if (start_ok) begin
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN, ST_HOLD: begin
                    if (expire) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        state_d = ST_RUN;
`else
                        state_d = ST_EXPIRED;
`endif
                    end else begin
                        state_d = i_PAUSE ? ST_HOLD : ST_RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Prescaler only advances in a cycle with pause low, so each
    // paused clock adds exactly one clock to the expiry latency.
    always_comb begin
        busy    = (state_q == ST_RUN) || (state_q == ST_HOLD);
        pre_en  = busy && !i_PAUSE;
        pre_clr = i_LOAD || start_ok;
    end

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        uf_d     = uf_q;
        done_d   = 1'b0;
        if (i_LOAD) begin
            count_d  = i_VALUE;
            reload_d = i_VALUE;
            uf_d     = 1'b0;
            if (i_START) begin
                presc_d = i_PRESCALE;
            end
        end else if (start_ok) begin
            count_d = reload_q;
            presc_d = i_PRESCALE;
            uf_d    = 1'b0;
        end else if (expire) begin
            uf_d   = 1'b1;
            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            count_d = reload_q;
            presc_d = i_PRESCALE;
`else
            count_d = '0;
`endif
        end else if (tick) begin
            count_d = count_q - COUNTER_BITS'(1);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            uf_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            uf_q     <= uf_d;
            done_q   <= done_d;
        end
    end

    assign o_COUNT     = count_q;
    assign o_BUSY      = busy;
    assign o_UNDERFLOW = uf_q;
    assign o_DONE      = done_q;

endmodule
